// File: rtl/vend_pkg.sv
// Shared definitions for the vending customer panel: FSM states, coin codes,
// coin values and the response timeout.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_REQUEST  = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_DISPENSE = 3'd4
  } vend_state_e;

  localparam logic [1:0] COIN_CODE_1   = 2'b00;
  localparam logic [1:0] COIN_CODE_2   = 2'b01;
  localparam logic [1:0] COIN_CODE_5   = 2'b10;
  localparam logic [1:0] COIN_CODE_BAD = 2'b11;

  localparam logic [3:0] COIN_VAL_1 = 4'd1;
  localparam logic [3:0] COIN_VAL_2 = 4'd2;
  localparam logic [3:0] COIN_VAL_5 = 4'd5;

  localparam logic [3:0] CREDIT_MAX  = 4'd15;
  localparam logic [3:0] RSP_TIMEOUT = 4'd15;

  // Value of a coin code; the invalid code maps to zero and is rejected anyway.
  function automatic logic [3:0] coin_amount(input logic [1:0] code);
    logic [3:0] amt;
    case (code)
      COIN_CODE_1: amt = COIN_VAL_1;
      COIN_CODE_2: amt = COIN_VAL_2;
      COIN_CODE_5: amt = COIN_VAL_5;
      default:     amt = 4'd0;
    endcase
    return amt;
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Refund down-counter: loaded with the amount to return, then emits one
// change_pulse per cycle until the count reaches zero.
module vend_change_dispenser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       busy,
  output logic       change_pulse
);

  logic [3:0] cnt_q, cnt_d;
  logic       pulse_q, pulse_d;

  // Next count and pulse: a load takes precedence, otherwise count down to zero.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_d   = cnt_q - 4'd1;
      pulse_d = 1'b1;
    end
  end

  // Count and pulse registers; reset abandons any refund in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign busy         = (cnt_q != 4'd0);
  assign change_pulse = pulse_q;

endmodule

// File: rtl/vend_customer_panel.sv
// Customer-facing panel of the vending machine: collects coins, forwards a
// purchase request to the vending core and returns change.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no credit, waiting for the first coin
// ST_COLLECT  | credit held, accepting coins, selection or cancel
// ST_REQUEST  | req_valid is high for this single cycle
// ST_WAIT_RSP | waiting for the core response, timeout down-counter running
// ST_DISPENSE | credit cleared, refund being paid out as change pulses
module vend_customer_panel
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       sel_valid,
  input  logic [1:0] sel_code,
  input  logic [2:0] sel_count,
  input  logic       cancel,
  output logic       req_valid,
  output logic [1:0] req_code,
  output logic [2:0] req_count,
  output logic [3:0] req_money,
  input  logic       rsp_valid,
  input  logic       rsp_ok,
  input  logic [3:0] rsp_remaining,
  output logic [3:0] credit,
  output logic       coin_reject,
  output logic       change_pulse,
  output logic       vend_done,
  output logic       vend_fail
);

  vend_state_e state_q, state_d;
  logic [3:0]  credit_q, credit_d;
  logic [3:0]  tmr_q, tmr_d;
  logic        req_valid_q, req_valid_d;
  logic [1:0]  req_code_q, req_code_d;
  logic [2:0]  req_count_q, req_count_d;
  logic [3:0]  req_money_q, req_money_d;
  logic        coin_reject_q, coin_reject_d;
  logic        vend_done_q, vend_done_d;
  logic        vend_fail_q, vend_fail_d;

  logic        disp_load;
  logic [3:0]  disp_val;
  logic        disp_busy;

  logic [4:0]  coin_sum;
  logic        coin_ok;
  logic [3:0]  credit_with_coin;

  // Coin acceptance: valid code and the new credit must still fit in 4 bits.
  always_comb begin
    coin_sum = {1'b0, credit_q} + {1'b0, coin_amount(coin_value)};
    coin_ok  = (coin_value != COIN_CODE_BAD) && (coin_sum <= {1'b0, CREDIT_MAX});
    credit_with_coin = (coin_valid && coin_ok) ? coin_sum[3:0] : credit_q;
  end

  // Next-state and registered-output logic for the panel FSM.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    tmr_d         = tmr_q;
    req_valid_d   = 1'b0;
    req_code_d    = 2'd0;
    req_count_d   = 3'd0;
    req_money_d   = 4'd0;
    coin_reject_d = 1'b0;
    vend_done_d   = 1'b0;
    vend_fail_d   = 1'b0;
    disp_load     = 1'b0;
    disp_val      = 4'd0;

    case (state_q)
      ST_IDLE: begin
        if (coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[3:0];
            state_d  = ST_COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      ST_COLLECT: begin
        if (cancel) begin
          // A coin arriving with cancel is handed straight back.
          coin_reject_d = coin_valid;
          disp_load     = 1'b1;
          disp_val      = credit_q;
          credit_d      = 4'd0;
          state_d       = ST_DISPENSE;
        end else begin
          coin_reject_d = coin_valid && !coin_ok;
          credit_d      = credit_with_coin;
          if (sel_valid) begin
            req_valid_d = 1'b1;
            req_code_d  = sel_code;
            req_count_d = sel_count;
            req_money_d = credit_with_coin;
            state_d     = ST_REQUEST;
          end
        end
      end

      ST_REQUEST: begin
        coin_reject_d = coin_valid;
        tmr_d         = RSP_TIMEOUT - 4'd1;
        state_d       = ST_WAIT_RSP;
      end

      ST_WAIT_RSP: begin
        coin_reject_d = coin_valid;
        if (rsp_valid) begin
          vend_done_d = rsp_ok;
          vend_fail_d = !rsp_ok;
          disp_load   = 1'b1;
          disp_val    = rsp_ok ? rsp_remaining : credit_q;
          credit_d    = 4'd0;
          tmr_d       = 4'd0;
          state_d     = ST_DISPENSE;
        end else if (tmr_q == 4'd0) begin
          vend_fail_d = 1'b1;
          disp_load   = 1'b1;
          disp_val    = credit_q;
          credit_d    = 4'd0;
          state_d     = ST_DISPENSE;
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end

      ST_DISPENSE: begin
        coin_reject_d = coin_valid;
        if (!disp_busy) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        credit_d = 4'd0;
        tmr_d    = 4'd0;
      end
    endcase
  end

  // State, credit, timer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= 4'd0;
      tmr_q         <= 4'd0;
      req_valid_q   <= 1'b0;
      req_code_q    <= 2'd0;
      req_count_q   <= 3'd0;
      req_money_q   <= 4'd0;
      coin_reject_q <= 1'b0;
      vend_done_q   <= 1'b0;
      vend_fail_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      tmr_q         <= tmr_d;
      req_valid_q   <= req_valid_d;
      req_code_q    <= req_code_d;
      req_count_q   <= req_count_d;
      req_money_q   <= req_money_d;
      coin_reject_q <= coin_reject_d;
      vend_done_q   <= vend_done_d;
      vend_fail_q   <= vend_fail_d;
    end
  end

  vend_change_dispenser u_dispenser (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (disp_load),
    .load_val     (disp_val),
    .busy         (disp_busy),
    .change_pulse (change_pulse)
  );

  assign req_valid   = req_valid_q;
  assign req_code    = req_code_q;
  assign req_count   = req_count_q;
  assign req_money   = req_money_q;
  assign credit      = credit_q;
  assign coin_reject = coin_reject_q;
  assign vend_done   = vend_done_q;
  assign vend_fail   = vend_fail_q;

endmodule

// File: tb/tb_vend_customer_panel.sv
// Directed bench for the vending customer panel. Inputs change on the falling
// edge; registered outputs are sampled on the falling edge as well.
module tb_vend_customer_panel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_value = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_code = 2'd0;
  logic [2:0] sel_count = 3'd0;
  logic       cancel = 1'b0;
  logic       req_valid;
  logic [1:0] req_code;
  logic [2:0] req_count;
  logic [3:0] req_money;
  logic       rsp_valid = 1'b0;
  logic       rsp_ok = 1'b0;
  logic [3:0] rsp_remaining = 4'd0;
  logic [3:0] credit;
  logic       coin_reject;
  logic       change_pulse;
  logic       vend_done;
  logic       vend_fail;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vend_customer_panel dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .coin_valid    (coin_valid),
    .coin_value    (coin_value),
    .sel_valid     (sel_valid),
    .sel_code      (sel_code),
    .sel_count     (sel_count),
    .cancel        (cancel),
    .req_valid     (req_valid),
    .req_code      (req_code),
    .req_count     (req_count),
    .req_money     (req_money),
    .rsp_valid     (rsp_valid),
    .rsp_ok        (rsp_ok),
    .rsp_remaining (rsp_remaining),
    .credit        (credit),
    .coin_reject   (coin_reject),
    .change_pulse  (change_pulse),
    .vend_done     (vend_done),
    .vend_fail     (vend_fail)
  );

  task automatic apply_reset();
    coin_valid = 0; sel_valid = 0; cancel = 0; rsp_valid = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // One-cycle coin strobe; returns on the edge where its effect is visible.
  task automatic coin(input logic [1:0] v);
    coin_value = v; coin_valid = 1;
    @(negedge clk);
    coin_valid = 0;
  endtask

  task automatic select(input logic [1:0] c, input logic [2:0] n);
    sel_code = c; sel_count = n; sel_valid = 1;
    @(negedge clk);
    sel_valid = 0;
  endtask

  task automatic respond(input logic ok, input logic [3:0] rem);
    rsp_ok = ok; rsp_remaining = rem; rsp_valid = 1;
    @(negedge clk);
    rsp_valid = 0;
  endtask

  task automatic count_window(input int n, output int pulses, output int dones,
                              output int fails, output int reqs);
    pulses = 0; dones = 0; fails = 0; reqs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pulses += int'(change_pulse);
      dones  += int'(vend_done);
      fails  += int'(vend_fail);
      reqs   += int'(req_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({req_valid, coin_reject, change_pulse, vend_done, vend_fail} !== 5'b0) begin
      $display("FAIL reset_pulses got=%b exp=00000",
               {req_valid, coin_reject, change_pulse, vend_done, vend_fail}); bad++;
    end
    total++;
    if (credit !== 4'd0 || req_money !== 4'd0) begin
      $display("FAIL reset_credit got credit=%0d money=%0d exp=0", credit, req_money); bad++;
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_purchase_ok();
    int p, d, f, r;
    apply_reset();
    coin(2'b10); coin(2'b10); coin(2'b01);
    total++;
    if (credit !== 4'd12) begin $display("FAIL ok_credit got=%0d exp=12", credit); bad++; end
    select(2'd1, 3'd2);
    total++;
    if ({req_valid, req_code, req_count, req_money} !== {1'b1, 2'd1, 3'd2, 4'd12}) begin
      $display("FAIL ok_req got v=%0d c=%0d n=%0d m=%0d exp v=1 c=1 n=2 m=12",
               req_valid, req_code, req_count, req_money); bad++;
    end
    @(negedge clk);
    total++;
    if (req_valid !== 1'b0) begin $display("FAIL ok_req_one_cycle got=%0d exp=0", req_valid); bad++; end
    respond(1'b1, 4'd4);
    total++;
    if (vend_done !== 1'b1 || vend_fail !== 1'b0 || credit !== 4'd0) begin
      $display("FAIL ok_done got done=%0d fail=%0d credit=%0d exp 1 0 0",
               vend_done, vend_fail, credit); bad++;
    end
    count_window(10, p, d, f, r);
    total++;
    if (p !== 4 || d !== 0) begin $display("FAIL ok_change got=%0d exp=4", p); bad++; end
    coin(2'b00);
    total++;
    if (credit !== 4'd1) begin $display("FAIL ok_back_idle credit got=%0d exp=1", credit); bad++; end
  endtask

  task automatic test_overflow();
    apply_reset();
    coin(2'b10); coin(2'b10); coin(2'b10);
    total++;
    if (credit !== 4'd15 || coin_reject !== 1'b0) begin
      $display("FAIL ovf_fill got credit=%0d rej=%0d exp 15 0", credit, coin_reject); bad++;
    end
    coin(2'b00);
    total++;
    if (coin_reject !== 1'b1 || credit !== 4'd15) begin
      $display("FAIL ovf_reject got rej=%0d credit=%0d exp 1 15", coin_reject, credit); bad++;
    end
    @(negedge clk);
    total++;
    if (coin_reject !== 1'b0) begin $display("FAIL ovf_reject_width got=%0d exp=0", coin_reject); bad++; end
    apply_reset();
    coin(2'b11);
    total++;
    if (coin_reject !== 1'b1 || credit !== 4'd0) begin
      $display("FAIL bad_code got rej=%0d credit=%0d exp 1 0", coin_reject, credit); bad++;
    end
  endtask

  task automatic test_rsp_fail();
    int p, d, f, r;
    apply_reset();
    coin(2'b01);
    select(2'd3, 3'd1);
    total++;
    if (req_money !== 4'd2) begin $display("FAIL fail_req_money got=%0d exp=2", req_money); bad++; end
    @(negedge clk);
    coin(2'b00);
    total++;
    if (coin_reject !== 1'b1 || credit !== 4'd2) begin
      $display("FAIL busy_coin got rej=%0d credit=%0d exp 1 2", coin_reject, credit); bad++;
    end
    respond(1'b0, 4'd9);
    total++;
    if (vend_fail !== 1'b1 || vend_done !== 1'b0) begin
      $display("FAIL fail_flag got fail=%0d done=%0d exp 1 0", vend_fail, vend_done); bad++;
    end
    count_window(8, p, d, f, r);
    total++;
    if (p !== 2) begin $display("FAIL fail_change got=%0d exp=2", p); bad++; end
  endtask

  task automatic test_timeout();
    int p, d, f, r;
    apply_reset();
    coin(2'b10);
    select(2'd0, 3'd1);
    total++;
    if (req_valid !== 1'b1) begin $display("FAIL to_req got=%0d exp=1", req_valid); bad++; end
    count_window(15, p, d, f, r);
    total++;
    if (f !== 0) begin $display("FAIL to_early got=%0d exp=0", f); bad++; end
    @(negedge clk);
    total++;
    if (vend_fail !== 1'b1 || credit !== 4'd0) begin
      $display("FAIL to_fail got fail=%0d credit=%0d exp 1 0", vend_fail, credit); bad++;
    end
    count_window(8, p, d, f, r);
    total++;
    if (p !== 5) begin $display("FAIL to_change got=%0d exp=5", p); bad++; end
    respond(1'b1, 4'd7);
    total++;
    if (vend_done !== 1'b0) begin $display("FAIL late_rsp_done got=%0d exp=0", vend_done); bad++; end
    count_window(6, p, d, f, r);
    total++;
    if (p + d + f !== 0) begin $display("FAIL late_rsp got=%0d exp=0", p + d + f); bad++; end
  endtask

  task automatic test_cancel();
    int p, d, f, r;
    apply_reset();
    coin(2'b01);
    cancel = 1; sel_code = 2'd2; sel_count = 3'd3; sel_valid = 1;
    @(negedge clk);
    cancel = 0; sel_valid = 0;
    total++;
    if (req_valid !== 1'b0 || credit !== 4'd0) begin
      $display("FAIL cancel_state got req=%0d credit=%0d exp 0 0", req_valid, credit); bad++;
    end
    count_window(8, p, d, f, r);
    total++;
    if (p !== 2 || r !== 0) begin $display("FAIL cancel_change got p=%0d r=%0d exp 2 0", p, r); bad++; end
  endtask

  task automatic test_reset_mid_dispense();
    int p, d, f, r;
    apply_reset();
    coin(2'b10);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    @(negedge clk);
    total++;
    if (change_pulse !== 1'b1) begin $display("FAIL mid_first_pulse got=%0d exp=1", change_pulse); bad++; end
    #1 rst_n = 0;
    #1;
    total++;
    if (change_pulse !== 1'b0 || credit !== 4'd0) begin
      $display("FAIL mid_async got pulse=%0d credit=%0d exp 0 0", change_pulse, credit); bad++;
    end
    @(negedge clk);
    rst_n = 1;
    count_window(8, p, d, f, r);
    total++;
    if (p !== 0) begin $display("FAIL mid_no_more got=%0d exp=0", p); bad++; end
    coin(2'b00);
    total++;
    if (credit !== 4'd1) begin $display("FAIL mid_resume got=%0d exp=1", credit); bad++; end
  endtask

  task automatic test_back_to_back();
    int p, d, f, r;
    apply_reset();
    select(2'd1, 3'd1);
    count_window(4, p, d, f, r);
    total++;
    if (r !== 0) begin $display("FAIL idle_sel got=%0d exp=0", r); bad++; end
    coin(2'b01);
    coin_value = 2'b10; coin_valid = 1; sel_code = 2'd0; sel_count = 3'd7; sel_valid = 1;
    @(negedge clk);
    coin_valid = 0; sel_valid = 0;
    total++;
    if (req_valid !== 1'b1 || req_money !== 4'd7 || req_count !== 3'd7 || credit !== 4'd7) begin
      $display("FAIL coin_sel got v=%0d m=%0d n=%0d credit=%0d exp 1 7 7 7",
               req_valid, req_money, req_count, credit); bad++;
    end
    @(negedge clk);
    respond(1'b1, 4'd0);
    total++;
    if (vend_done !== 1'b1) begin $display("FAIL zero_done got=%0d exp=1", vend_done); bad++; end
    count_window(4, p, d, f, r);
    total++;
    if (p !== 0) begin $display("FAIL zero_change got=%0d exp=0", p); bad++; end
    coin(2'b00);
    total++;
    if (credit !== 4'd1 || coin_reject !== 1'b0) begin
      $display("FAIL zero_idle got credit=%0d rej=%0d exp 1 0", credit, coin_reject); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_purchase_ok();
    test_overflow();
    test_rsp_fail();
    test_timeout();
    test_cancel();
    test_reset_mid_dispense();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
